sipo_rx: RTL and testbench
==========================

SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 Parameter: WIDTH, default 4, number of bits per parallel word (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 clr  input  1  synchronous clear of frame and status state, active-high.
REQ-005 si_en  input  1  bit strobe; si is sampled only on cycles where si_en=1.
REQ-006 si  input  1  serial data bit, MSB of each word first.
REQ-007 po_ready  input  1  consumer accepts po this cycle when po_valid=1.
REQ-008 po  output  WIDTH  last completed parallel word.
REQ-009 po_valid  output  1  po holds a word not yet accepted.
REQ-010 overrun  output  1  sticky flag; a completed word was dropped.
REQ-011 busy  output  1  a partial frame is in progress (1..WIDTH-1 bits held).

Function
REQ-012 The block SHALL hold an internal shift register sr[WIDTH-1:0] and a bit counter cnt (0..WIDTH-1).
REQ-013 The block SHALL use a two-state FSM: IDLE (cnt=0, no partial bits) and SHIFT (cnt>0).
REQ-014 si_en=1 in IDLE SHALL load si into sr[0], set cnt=1, and go to SHIFT.
REQ-015 si_en=1 in SHIFT with cnt<WIDTH-1 SHALL shift sr <= {sr[WIDTH-2:0], si} and increment cnt.
REQ-016 si_en=1 in SHIFT with cnt=WIDTH-1 SHALL complete the frame: word = {sr[WIDTH-2:0], si}, cnt=0, FSM to IDLE.
REQ-017 The first bit received in a frame SHALL appear at po[WIDTH-1] and the last at po[0].
REQ-018 si_en=0 SHALL leave sr, cnt and FSM state unchanged; gaps between bits of any length are allowed.
REQ-019 Output register update on frame completion SHALL take effect at the same clock edge that samples the last bit, so po_valid=1 is visible on the cycle after that edge (latency 1 cycle).
REQ-020 po_valid SHALL clear on an edge where po_valid=1 and po_ready=1, unless a frame completes at that same edge.
REQ-021 Frame completion with po_valid=0, or with po_valid=1 and po_ready=1, SHALL load po with the new word and set po_valid=1 (back-to-back, no bubble, no overrun).
REQ-022 Frame completion with po_valid=1 and po_ready=0 SHALL leave po and po_valid unchanged, discard the new word, and set overrun=1.
REQ-023 overrun SHALL remain 1 until clr=1 or reset; po_ready SHALL NOT clear it.
REQ-024 po SHALL hold its value while po_valid=0; po_ready with po_valid=0 SHALL have no effect.
REQ-025 busy SHALL be 1 exactly when the FSM is in SHIFT.
REQ-026 clr=1 SHALL set sr=0, cnt=0, FSM=IDLE, po_valid=0, overrun=0, po=0, and SHALL take priority over si_en and po_ready in the same cycle.
REQ-027 WIDTH=1-bit arithmetic SHALL NOT be required; cnt width SHALL be sized to hold WIDTH-1 with no wrap.

Reset
REQ-028 rst=0 SHALL immediately, without a clock edge, force sr=0, cnt=0, FSM=IDLE, po=0, po_valid=0, overrun=0, busy=0.
REQ-029 Assertion of rst mid-frame SHALL discard all partial bits; the first si_en=1 after release SHALL start a new frame.
REQ-030 While rst=0, si_en, si, clr and po_ready SHALL be ignored.

Verification (WIDTH=4)
REQ-031 Reset: drive rst=0 with random inputs -> po=4'b0000, po_valid=0, overrun=0, busy=0 throughout.
REQ-032 Basic frame: si_en=1 for 4 consecutive cycles with si=1,0,1,1, po_ready=0 -> busy=1 after bit 1, busy=0 and po=4'b1011, po_valid=1 one cycle after bit 4.
REQ-033 Gapped frame: same bits with 3 idle cycles (si_en=0, si toggling) between each -> po=4'b1011, po_valid=1; idle-cycle si values are not captured.
REQ-034 Overrun: with po=4'b1011 pending and po_ready=0, shift 0,1,1,0 -> po stays 4'b1011, overrun=1; then po_ready=1 for one cycle -> po_valid=0, overrun stays 1 until clr=1.
REQ-035 Back-to-back: po_ready=1 on the same edge the 4th bit of 1,1,0,0 is sampled while 4'b1011 is pending -> po=4'b1100, po_valid remains 1, overrun=0.
REQ-036 Reset mid-frame: shift 1,1 then pulse rst=0, then shift 0,1,0,1 -> po=4'b0101, po_valid=1, no residue of the aborted bits.

Source files
------------

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: assembles MSB-first bits, strobed by si_en,
// into WIDTH-bit words presented on a valid/ready output with a sticky overrun flag.
module sipo_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             si_en,
  input  logic             si,
  input  logic             po_ready,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  output logic             overrun,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             po_valid_q, po_valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_done;
  logic [WIDTH-1:0] word;

  assign word = {sr_q[WIDTH-2:0], si};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      po_q       <= '0;
      po_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      po_q       <= po_d;
      po_valid_q <= po_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    po_d       = po_q;
    po_valid_d = po_valid_q;
    overrun_d  = overrun_q;
    frame_done = 1'b0;

    if (clr) begin
      state_d    = IDLE;
      cnt_d      = '0;
      sr_d       = '0;
      po_d       = '0;
      po_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (si_en) begin
            sr_d    = {{(WIDTH-1){1'b0}}, si};
            cnt_d   = CNT_W'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (si_en) begin
            sr_d = word;
            if (cnt_q == CNT_LAST) begin
              cnt_d      = '0;
              state_d    = IDLE;
              frame_done = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // A completed word may replace one being accepted this edge; otherwise it is dropped.
      if (frame_done) begin
        if (!po_valid_q || po_ready) begin
          po_d       = word;
          po_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else if (po_valid_q && po_ready) begin
        po_valid_d = 1'b0;
      end
    end
  end

  assign po       = po_q;
  assign po_valid = po_valid_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q == SHIFT);

endmodule

// File: tb/tb_sipo_rx.sv
// Randomised and directed bench for sipo_rx (WIDTH=4): a bit-list reference model
// feeds a scoreboard queue that an independent monitor drains on each handshake.
module tb_sipo_rx;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clr = 1'b0;
  logic         si_en = 1'b0;
  logic         si = 1'b0;
  logic         po_ready = 1'b0;
  logic [W-1:0] po;
  logic         po_valid;
  logic         overrun;
  logic         busy;

  sipo_rx #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .si_en    (si_en),
    .si       (si),
    .po_ready (po_ready),
    .po       (po),
    .po_valid (po_valid),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: bits collected so far in the current frame, plus the output slot.
  int exp_q[$];
  int m_bits[$];
  int m_word  = 0;
  bit m_valid = 1'b0;
  bit m_over  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    if (m_valid) void'(exp_q.pop_back());
    m_valid = 1'b0;
    m_over  = 1'b0;
    m_word  = 0;
    m_bits.delete();
  endtask

  // Applies the inputs currently on the pins as the DUT sees them at this rising edge.
  task automatic model_step();
    int  w;
    bit  done;
    if (!rst) begin
      model_reset();
    end else if (clr) begin
      // A word accepted at this edge has already been consumed by the monitor.
      if (m_valid && po_ready) m_valid = 1'b0;
      model_reset();
    end else begin
      done = 1'b0;
      w    = 0;
      if (si_en) m_bits.push_back(int'(si));
      if (m_bits.size() == W) begin
        foreach (m_bits[i]) w = w * 2 + m_bits[i];
        m_bits.delete();
        done = 1'b1;
      end
      if (done) begin
        if (!m_valid || po_ready) begin
          m_word  = w;
          m_valid = 1'b1;
          exp_q.push_back(w);
        end else begin
          m_over = 1'b1;
        end
      end else if (m_valid && po_ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic drive(input bit en, input bit s, input bit rdy, input bit c);
    @(posedge clk);
    model_step();
    #1;
    si_en    = en;
    si       = s;
    po_ready = rdy;
    clr      = c;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'($urandom), 1'b0, 1'b0);
  endtask

  task automatic send(input logic [W-1:0] wd, input int gap, input bit rdy_last);
    for (int b = W - 1; b >= 0; b--) begin
      drive(1'b1, wd[b], (b == 0) ? rdy_last : 1'b0, 1'b0);
      if (b != 0) idle(gap);
    end
  endtask

  task automatic set_rst(input bit v);
    @(posedge clk);
    model_step();
    #1;
    rst      = v;
    si_en    = 1'b0;
    clr      = 1'b0;
    po_ready = 1'b0;
    if (!v) begin
      model_reset();
      #1;
      chk("async_rst_po", po, 0);
      chk("async_rst_valid", po_valid, 0);
      chk("async_rst_overrun", overrun, 0);
      chk("async_rst_busy", busy, 0);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("po", po, m_word);
    chk("po_valid", po_valid, m_valid);
    chk("overrun", overrun, m_over);
    chk("busy", busy, m_bits.size() != 0);
  end

  // Scoreboard monitor: one transaction per accepted word.
  always @(negedge clk) begin
    int e;
    if (rst && po_valid && po_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errs++;
        $display("FAIL accept_unexpected: got %b expected no word at %0t", po, $time);
      end else begin
        e = exp_q.pop_front();
        $display("accept po=%b expected=%b", po, e[W-1:0]);
        if (po !== e[W-1:0]) begin
          n_errs++;
          $display("FAIL accept_word: got %b expected %b at %0t", po, e[W-1:0], $time);
        end
      end
    end
  end

  initial begin
    // Held in reset with random activity on every input.
    for (int k = 0; k < 6; k++)
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    set_rst(1'b1);

    // Basic frame 1,0,1,1 with no consumer.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("basic_busy_after_bit1", busy, 1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("basic_po", po, 4'b1011);
    chk("basic_valid", po_valid, 1);
    chk("basic_busy", busy, 0);

    // Overrun while 1011 is pending.
    send(4'b0110, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovr_po_kept", po, 4'b1011);
    chk("ovr_flag", overrun, 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovr_valid_cleared", po_valid, 0);
    chk("ovr_sticky", overrun, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("clr_overrun", overrun, 0);
    chk("clr_po", po, 0);

    // Gapped frame with toggling si between strobes.
    send(4'b1011, 3, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("gap_po", po, 4'b1011);
    chk("gap_valid", po_valid, 1);

    // Back-to-back: accept 1011 on the edge that completes 1100.
    send(4'b1100, 0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_po", po, 4'b1100);
    chk("b2b_valid", po_valid, 1);
    chk("b2b_overrun", overrun, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-frame discards partial bits.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    set_rst(1'b0);
    for (int k = 0; k < 3; k++)
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    set_rst(1'b1);
    send(4'b0101, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_mid_po", po, 4'b0101);
    chk("rst_mid_valid", po_valid, 1);

    // Random traffic with occasional clears.
    for (int k = 0; k < 400; k++)
      drive(1'($urandom_range(0, 1)), 1'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 39) == 0));

    // Drain and confirm nothing remains outstanding.
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
